// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: step states,
// supported opcodes and IR field positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam int OPC_WIDTH = 5;
  localparam int REG_IDX_W = 4;

  localparam int IR_OPC_MSB = 31;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RC_MSB  = 18;

  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00000;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00001;
  localparam logic [OPC_WIDTH-1:0] OPC_AND  = 5'b00010;
  localparam logic [OPC_WIDTH-1:0] OPC_OR   = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OPC_MUL  = 5'b01110;
  localparam logic [OPC_WIDTH-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 5'b11011;

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot enable; purely combinational, zero latency,
// no flow control. All-zero output when disabled.
module reg_select_decoder
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [REG_IDX_W-1:0] idx_i,
  input  logic                 en_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 fetch/ALU sequencer; one step per clock, T1 stalls until mem_ready.
// ILLEGAL_TRAP_EN: unsupported opcodes halt the sequencer instead of acting as NOP.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = OPC_WIDTH
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPC_W-1:0]    alu_op,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                halted,
  output logic                illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   t1_wait_q, t1_wait_d;

  logic [OPC_W-1:0]     opc;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic                 is_3reg, is_muldiv, is_halt;
  logic                 rin_en, rout_en;
  logic [REG_IDX_W-1:0] rin_idx, rout_idx;
  logic                 unused_ir_bits;

  assign opc = ir[IR_OPC_MSB -: OPC_W];
  assign ra  = ir[IR_RA_MSB -: REG_IDX_W];
  assign rb  = ir[IR_RB_MSB -: REG_IDX_W];
  assign rc  = ir[IR_RC_MSB -: REG_IDX_W];
  assign unused_ir_bits = ^ir[IR_RC_MSB-REG_IDX_W:0];

  assign is_3reg   = (opc == OPC_ADD) || (opc == OPC_SUB) ||
                     (opc == OPC_AND) || (opc == OPC_OR);
  assign is_muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
  assign is_halt   = (opc == OPC_HALT);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    t1_wait_d = 1'b0;
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    ZLowIn    = 1'b0;
    ZHighIn   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    alu_op    = '0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rin_idx   = ra;
    rout_idx  = rb;

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        // The incremented PC is latched once; wait cycles only re-strobe the read.
        Zlowout = 1'b1;
        PCin    = !t1_wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = S_T2;
        else           t1_wait_d = 1'b1;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_3reg || is_muldiv) begin
          rout_en   = 1'b1;
          rout_idx  = is_muldiv ? ra : rb;
          Yin       = 1'b1;
          illegal_d = 1'b0;
          state_d   = S_T4;
        end else if (is_halt) begin
          illegal_d = 1'b0;
          state_d   = S_HALT;
        end else begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_HALT;
`else
          state_d   = S_T0;
`endif
        end
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_idx = is_muldiv ? rb : rc;
        alu_op   = opc;
        ZLowIn   = 1'b1;
        ZHighIn  = is_muldiv;
        state_d  = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          rin_en  = 1'b1;
          state_d = S_T0;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = S_T0;
      end
      S_HALT: if (start) state_d = S_T0;
      default: state_d = S_IDLE;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx_i    (rin_idx),
    .en_i     (rin_en),
    .onehot_o (r_in)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (r_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: each vector drives inputs for one
// cycle and gives the outputs expected after the following rising edge.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b1;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  alu_op;
  logic [15:0] r_in, r_out;
  logic        halted, illegal;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .alu_op(alu_op), .r_in(r_in), .r_out(r_out),
    .halted(halted), .illegal(illegal)
  );

  localparam logic [14:0] B_PCOUT = 15'h4000, B_MARIN = 15'h2000, B_INCPC = 15'h1000,
                          B_PCIN  = 15'h0800, B_READ  = 15'h0400, B_MDRIN = 15'h0200,
                          B_MDROUT= 15'h0100, B_IRIN  = 15'h0080, B_YIN   = 15'h0040,
                          B_ZLIN  = 15'h0020, B_ZHIN  = 15'h0010, B_ZLOUT = 15'h0008,
                          B_ZHOUT = 15'h0004, B_HIIN  = 15'h0002, B_LOIN  = 15'h0001;
  localparam logic [14:0] S_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [14:0] S_T1  = B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [14:0] S_T1W = B_ZLOUT | B_READ | B_MDRIN;
  localparam logic [14:0] S_T2  = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_DIV  = 32'h7930_0000; // div R2,R6
  localparam logic [31:0] IR_ADD  = 32'h0091_8000; // add R1,R2,R3
  localparam logic [31:0] IR_OR   = 32'h1A2B_0000; // or R4,R5,R6
  localparam logic [31:0] IR_BAD  = 32'hA800_0000; // opcode 10101
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  typedef struct {
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic [14:0] strb;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        halted;
    logic        illegal;
  } vec_t;

  vec_t tbl[$];

  wire [14:0] act_strb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                          Yin, ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin};

  function automatic vec_t mk(input logic st, input logic mr, input logic [31:0] i,
                              input logic [14:0] s, input logic [4:0] a,
                              input logic [15:0] ri, input logic [15:0] ro,
                              input logic h, input logic il);
    vec_t v;
    v.start = st; v.mem_ready = mr; v.ir = i; v.strb = s; v.alu = a;
    v.rin = ri; v.rout = ro; v.halted = h; v.illegal = il;
    return v;
  endfunction

  task automatic check(input vec_t v, input string nm);
    logic [53:0] act, exp;
    act = {act_strb, alu_op, r_in, r_out, halted, illegal};
    exp = {v.strb, v.alu, v.rin, v.rout, v.halted, v.illegal};
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got strb=%h alu=%h rin=%h rout=%h halted=%b illegal=%b; want strb=%h alu=%h rin=%h rout=%h halted=%b illegal=%b",
               nm, act_strb, alu_op, r_in, r_out, halted, illegal,
               v.strb, v.alu, v.rin, v.rout, v.halted, v.illegal);
    end
    n_checks++;
    if ($countones({PCout, MDRout, Zlowout, Zhighout, r_out}) > 1) begin
      n_err++;
      $display("FAIL %s_bus: got %0d bus drivers, want at most 1", nm,
               $countones({PCout, MDRout, Zlowout, Zhighout, r_out}));
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    start = v.start; mem_ready = v.mem_ready; ir = v.ir;
    @(posedge clock);
    #1;
    check(v, nm);
  endtask

  initial begin
    // Idle/reset rows, then div R2,R6 (7 steps), add R1,R2,R3 (6 steps),
    // or R4,R5,R6 with three memory wait cycles in T1.
    tbl.push_back(mk(0, 1, IR_DIV, 15'h0,         5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(1, 1, IR_DIV, S_T0,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, S_T1,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, S_T2,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, B_YIN,         5'h00, 16'h0,    16'h0004, 0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, B_ZLIN|B_ZHIN, 5'h0F, 16'h0,    16'h0040, 0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, B_ZLOUT|B_LOIN,5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_DIV, B_ZHOUT|B_HIIN,5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_ADD, S_T0,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(1, 1, IR_ADD, S_T1,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(1, 1, IR_ADD, S_T2,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_ADD, B_YIN,         5'h00, 16'h0,    16'h0004, 0, 0));
    tbl.push_back(mk(0, 1, IR_ADD, B_ZLIN,        5'h00, 16'h0,    16'h0008, 0, 0));
    tbl.push_back(mk(0, 1, IR_ADD, B_ZLOUT,       5'h00, 16'h0002, 16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_ADD, S_T0,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 0, IR_OR,  S_T1,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 0, IR_OR,  S_T1W,         5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 0, IR_OR,  S_T1W,         5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 0, IR_OR,  S_T1W,         5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_OR,  S_T2,          5'h00, 16'h0,    16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_OR,  B_YIN,         5'h00, 16'h0,    16'h0020, 0, 0));
    tbl.push_back(mk(0, 1, IR_OR,  B_ZLIN,        5'h03, 16'h0,    16'h0040, 0, 0));
    tbl.push_back(mk(0, 1, IR_OR,  B_ZLOUT,       5'h00, 16'h0010, 16'h0,    0, 0));
    tbl.push_back(mk(0, 1, IR_OR,  S_T0,          5'h00, 16'h0,    16'h0,    0, 0));

    #2;
    check(mk(0, 1, IR_DIV, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "reset");
    @(posedge clock);
    #1;
    clear = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Unsupported opcode: no strobes at T3, then illegal latches.
    apply(mk(0, 1, IR_BAD, S_T1,  5'h0, 16'h0, 16'h0, 0, 0), "bad_t1");
    apply(mk(0, 1, IR_BAD, S_T2,  5'h0, 16'h0, 16'h0, 0, 0), "bad_t2");
    apply(mk(0, 1, IR_BAD, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "bad_t3");
`ifdef ILLEGAL_TRAP_EN
    apply(mk(0, 1, IR_BAD, 15'h0, 5'h0, 16'h0, 16'h0, 1, 1), "bad_trap");
    apply(mk(1, 1, IR_ADD, S_T0,  5'h0, 16'h0, 16'h0, 0, 1), "bad_resume");
`else
    apply(mk(0, 1, IR_BAD, S_T0,  5'h0, 16'h0, 16'h0, 0, 1), "bad_nop");
`endif
    // A good opcode clears the sticky flag at its T3 edge.
    apply(mk(0, 1, IR_ADD, S_T1,   5'h0, 16'h0, 16'h0,    0, 1), "clr_t1");
    apply(mk(0, 1, IR_ADD, S_T2,   5'h0, 16'h0, 16'h0,    0, 1), "clr_t2");
    apply(mk(0, 1, IR_ADD, B_YIN,  5'h0, 16'h0, 16'h0004, 0, 1), "clr_t3");
    apply(mk(0, 1, IR_ADD, B_ZLIN, 5'h0, 16'h0, 16'h0008, 0, 0), "clr_t4");
    apply(mk(0, 1, IR_ADD, B_ZLOUT,5'h0, 16'h0002, 16'h0, 0, 0), "clr_t5");
    apply(mk(0, 1, IR_HALT, S_T0,  5'h0, 16'h0, 16'h0,    0, 0), "halt_t0");

    apply(mk(0, 1, IR_HALT, S_T1,  5'h0, 16'h0, 16'h0, 0, 0), "halt_t1");
    apply(mk(0, 1, IR_HALT, S_T2,  5'h0, 16'h0, 16'h0, 0, 0), "halt_t2");
    apply(mk(0, 1, IR_HALT, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "halt_t3");
    apply(mk(0, 1, IR_HALT, 15'h0, 5'h0, 16'h0, 16'h0, 1, 0), "halt_enter");
    apply(mk(0, 1, IR_HALT, 15'h0, 5'h0, 16'h0, 16'h0, 1, 0), "halt_hold");
    apply(mk(1, 1, IR_DIV,  S_T0,  5'h0, 16'h0, 16'h0, 0, 0), "halt_resume");

    // Clear mid-T4 of a divide: strobes must fall with no clock edge.
    apply(mk(0, 1, IR_DIV, S_T1,          5'h00, 16'h0, 16'h0,    0, 0), "rst_t1");
    apply(mk(0, 1, IR_DIV, S_T2,          5'h00, 16'h0, 16'h0,    0, 0), "rst_t2");
    apply(mk(0, 1, IR_DIV, B_YIN,         5'h00, 16'h0, 16'h0004, 0, 0), "rst_t3");
    apply(mk(0, 1, IR_DIV, B_ZLIN|B_ZHIN, 5'h0F, 16'h0, 16'h0040, 0, 0), "rst_t4");
    #1;
    clear = 1'b0;
    #1;
    check(mk(0, 1, IR_DIV, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "rst_async");
    @(posedge clock);
    #1;
    check(mk(0, 1, IR_DIV, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "rst_held");
    clear = 1'b1;
    apply(mk(0, 1, IR_DIV, 15'h0, 5'h0, 16'h0, 16'h0, 0, 0), "rst_idle");
    apply(mk(1, 1, IR_DIV, S_T0,  5'h0, 16'h0, 16'h0, 0, 0), "rst_start");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the DataPath control strobes for instruction fetch and register-register ALU execution.
- It takes over the sequencing that the datapath benches currently hand-drive: T0..T6 steps, one clock per step.
- Sits beside DataPath; consumes the IR contents and a memory-ready handshake; produces every in/out/ALU strobe.

Parameters:
- NUM_REGS, 16, number of general registers; r_in/r_out are one-hot of this width.
- OPC_W, 5, opcode field width (IR[31:27]).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clear  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  leave IDLE/HALT and begin fetch at next edge.
- ir  in  32  current IR contents from DataPath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
- ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes.
- alu_op  out  5  opcode presented to ALU; 0 when no ALU step.
- r_in  out  NUM_REGS  one-hot register load enables.
- r_out  out  NUM_REGS  one-hot register drive enables.
- halted  out  1  sequencer in HALT.
- illegal  out  1  sticky; last decoded opcode was unsupported.

Behaviour:
- Instruction fields: opc = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- Supported opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, MUL 01110, DIV 01111, HALT 11011.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. One state per cycle, except T1, which waits on the memory handshake.
- Strobes are a Moore-style combinational decode of the registered state and ir. In IDLE and HALT every strobe is 0, alu_op is 0, and r_in/r_out are 0.
- Reset (clear=0): state goes to IDLE immediately (async); illegal=0; halted=0. This applies mid-instruction as well: all strobes drop without waiting for a clock edge.
- IDLE: stay until start=1, then go to T0.
- T0: PCout, MARin, IncPC, ZLowIn. Go to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - PCin asserts only in the first T1 cycle.
  - Read and MDRin stay high while mem_ready=0.
  - Go to T2 on mem_ready=1.
- T2: MDRout, IRin. Go to T3. ir is valid from T3 on.
- T3, decoded from opc:
  - ADD/SUB/AND/OR: r_out[Rb], Yin. Go to T4.
  - MUL/DIV: r_out[Ra], Yin. Go to T4.
  - HALT: go to HALT.
  - Other opcode: set illegal and go to T0 (treated as NOP, PC already incremented).
- T4:
  - Three-register ops: r_out[Rc], alu_op=opc, ZLowIn. Go to T5.
  - MUL/DIV: r_out[Rb], alu_op=opc, ZLowIn, ZHighIn. Go to T5.
- T5:
  - Three-register ops: Zlowout, r_in[Ra]. Go to T0.
  - MUL/DIV: Zlowout, LOin. Go to T6.
- T6 (MUL/DIV only): Zhighout, HIin. Go to T0.
- HALT: halted=1; start=1 returns to T0. The illegal flag clears on any successfully decoded opcode at T3.
- Latency:
  - Three-register op: 6 cycles.
  - MUL/DIV: 7 cycles, with zero-wait memory.
  - Each mem_ready=0 cycle adds one cycle.
- Invariant: at most one bus driver (PCout, MDRout, Zlowout, Zhighout, any r_out bit) is high in any cycle.
- start is ignored outside IDLE/HALT.

Optional Feature:
- ILLEGAL_TRAP_EN.
  - Defined: an unsupported opcode at T3 sets illegal and goes to HALT (halted=1) instead of T0.
  - Undefined: NOP behaviour as above.

Decomposition:
- Shared package ctrl_pkg:
  - state enum;
  - opcode localparams: OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV, OPC_HALT;
  - IR field bit positions.
- One sub-module, reg_select_decoder: maps a 4-bit index plus an enable to a NUM_REGS one-hot vector. Instantiated twice, once for r_in and once for r_out.

Test Plan:
- Reset then start=1, ir=0x79300000 (div R2,R6), mem_ready tied 1:
  - required sequence T0..T6 over 7 cycles;
  - T3 r_out=0x0004, Yin;
  - T4 r_out=0x0040, alu_op=01111, ZLowIn+ZHighIn;
  - T5 LOin; T6 HIin.
  - With DataPath R2=307, R6=30: LO=10, HI=7.
- ADD R1,R2,R3 (ir=0x00918000):
  - T3 r_out=0x0004, T4 r_out=0x0008, alu_op=0;
  - T5 r_in=0x0002 with Zlowout;
  - back to T0 after 6 cycles.
- mem_ready low for 3 cycles in T1:
  - Read/MDRin held 4 cycles, PCin high only in the first;
  - T2 follows the cycle mem_ready=1.
- Opcode 10101 at T3:
  - illegal=1 and return to T0 with no r_in asserted;
  - with ILLEGAL_TRAP_EN, halted=1 instead.
- HALT opcode (ir=0xD8000000): halted=1 and strobes 0; start=1 resumes at T0.
- clear=0 asserted mid-T4 with no clock edge: all strobes 0 immediately; after release, state IDLE until start.
